fmc: RTL and testbench

- Read-only flash memory controller between the digit-recognizer datapath and an external 16-bit asynchronous parallel flash.
- On a one-cycle `ready` request it latches the request address and drives it to the flash.
- It holds the chip-enable and output-enable strobes (active-low) for a fixed read-access window, then registers the flash data onto `data_out`.

---
 rtl/fmc.sv | 117 +++++++++++
 tb/tb_fmc.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fmc.sv
//------------------------------------------------------------------------------
// Module      : fmc
// Description : Read-only controller for a 16-bit asynchronous parallel flash.
//               Optional one-deep request queue: define FMC_REQ_QUEUE_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fmc #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int READ_CYCLES = 11
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ready,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] address_in,
    output logic              ce,
    output logic              oe,
    output logic              we
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_READ = 1'b1;
    localparam logic [7:0] c_LOAD    = 8'(READ_CYCLES - 1);

    logic [0:0]        r_state, w_state_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_dout, w_dout_nxt;
`ifdef FMC_REQ_QUEUE_EN
    logic              r_pend_vld, w_pend_vld_nxt;
    logic [ADDR_W-1:0] r_pend_addr, w_pend_addr_nxt;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 8'd0;
            r_addr  <= '0;
            r_dout  <= '0;
`ifdef FMC_REQ_QUEUE_EN
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_dout  <= w_dout_nxt;
`ifdef FMC_REQ_QUEUE_EN
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_addr <= w_pend_addr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_dout_nxt  = r_dout;
`ifdef FMC_REQ_QUEUE_EN
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_addr_nxt = r_pend_addr;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (ready) begin
                    w_state_nxt = c_ST_READ;
                    w_cnt_nxt   = c_LOAD;
                    w_addr_nxt  = address;
                end
            end
            default: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
`ifdef FMC_REQ_QUEUE_EN
                    if (ready) begin
                        w_pend_vld_nxt  = 1'b1;
                        w_pend_addr_nxt = address;
                    end
`endif
                end else begin
                    // Flash data is sampled on the last cycle of the access window.
                    w_dout_nxt = data;
                    if (ready) begin
                        w_cnt_nxt  = c_LOAD;
                        w_addr_nxt = address;
`ifdef FMC_REQ_QUEUE_EN
                        w_pend_vld_nxt = 1'b0;
                    end else if (r_pend_vld) begin
                        w_cnt_nxt      = c_LOAD;
                        w_addr_nxt     = r_pend_addr;
                        w_pend_vld_nxt = 1'b0;
`endif
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
        endcase
    end

    // Strobes come straight from the single state flop, so they are glitch-free.
    assign ce         = (r_state != c_ST_READ);
    assign oe         = (r_state != c_ST_READ);
    assign we         = 1'b1;
    assign address_in = r_addr;
    assign data_out   = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_fmc.sv
//------------------------------------------------------------------------------
// Module      : tb_fmc
// Description : Randomised self-checking bench for fmc against a deadline-based
//               read model. Honours FMC_REQ_QUEUE_EN when defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fmc;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int READ_CYCLES = 11;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              ready = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] address_in;
    logic              ce, oe, we;

    int n_tests = 0;
    int n_fail  = 0;

    fmc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_CYCLES(READ_CYCLES)) u_dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .ready      (ready),
        .address    (address),
        .data       (data),
        .data_out   (data_out),
        .address_in (address_in),
        .ce         (ce),
        .oe         (oe),
        .we         (we)
    );

    always #5 clk = ~clk;

    // Flash contents: a fixed scramble of the address, nonzero at address 0.
    function automatic logic [DATA_W-1:0] flash_val(input logic [ADDR_W-1:0] a);
        return (a * 16'h9e37) ^ 16'h5a5a;
    endfunction

    assign data = flash_val(address_in);

    // Model: a read accepted on edge e completes on edge e+READ_CYCLES.
    int                m_edge;
    bit                m_busy;
    int                m_done_at;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_dout;
    bit                m_pv;
    logic [ADDR_W-1:0] m_pa;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, m_edge, got, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".ce"},         32'(ce),         32'(!m_busy));
        check({ctx, ".oe"},         32'(oe),         32'(!m_busy));
        check({ctx, ".we"},         32'(we),         32'd1);
        check({ctx, ".address_in"}, 32'(address_in), 32'(m_addr));
        check({ctx, ".data_out"},   32'(data_out),   32'(m_dout));
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_done_at = 0; m_addr = '0; m_dout = '0; m_pv = 1'b0; m_pa = '0;
    endtask

    task automatic model_edge(input bit r, input logic [ADDR_W-1:0] a);
        m_edge++;
        if (!m_busy) begin
            if (r) begin
                m_busy = 1'b1; m_addr = a; m_done_at = m_edge + READ_CYCLES;
            end
        end else if (m_edge == m_done_at) begin
            m_dout = flash_val(m_addr);
            if (r) begin
                m_addr = a; m_done_at = m_edge + READ_CYCLES; m_pv = 1'b0;
            end else if (m_pv) begin
                m_addr = m_pa; m_done_at = m_edge + READ_CYCLES; m_pv = 1'b0;
            end else begin
                m_busy = 1'b0;
            end
        end else if (r) begin
`ifdef FMC_REQ_QUEUE_EN
            m_pv = 1'b1; m_pa = a;
`endif
        end
    endtask

    // One clock: drive at negedge, advance model, check just after posedge.
    task automatic step(input bit r, input logic [ADDR_W-1:0] a, input string ctx);
        @(negedge clk);
        ready = r; address = a;
        model_edge(r, a);
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic idle(input int n, input string ctx);
        for (int i = 0; i < n; i++) step(1'b0, 16'(i * 7), ctx);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        ready = 1'b0;
        n_rst = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_all("rst_hold");
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        m_edge = 0;
        model_reset();
        #1;
        check_all("rst_init");
        pulse_reset(3);
        idle(20, "idle_hold");

        // Single read
        step(1'b1, 16'd3, "single");
        idle(14, "single");

        // Back-to-back: second request on the completing edge
        step(1'b1, 16'd3, "b2b");
        idle(READ_CYCLES - 1, "b2b");
        step(1'b1, 16'd5, "b2b");
        idle(14, "b2b");

        // Request during a busy read
        step(1'b1, 16'd2, "busy");
        idle(3, "busy");
        step(1'b1, 16'd1, "busy");
        idle(2 * READ_CYCLES + 4, "busy");

        // Reset in the middle of a read, then a normal read of address 0
        step(1'b1, 16'd4, "midrst");
        idle(5, "midrst");
        pulse_reset(2);
        step(1'b1, 16'd0, "post_rst");
        idle(14, "post_rst");

        // Randomised traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) pulse_reset($urandom_range(1, 3));
            else step($urandom_range(0, 3) == 0, 16'($urandom), "rand");
        end
        idle(READ_CYCLES * 3, "drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
